// File: rtl/weight_tile_loader.sv
// weight_tile_loader: fetches packed 3x3 weight tiles from weight DRAM and
// pushes them one byte per cycle into the weight FIFO with row/col tags.
module weight_tile_loader #(
   parameter int unsigned ADDR_W     = 24,
   parameter int unsigned TILE_ELEMS = 9,
   parameter int unsigned BEATS_TILE = 5
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              cmd_start,
   input  logic [ADDR_W-1:0] cmd_addr,
   input  logic [7:0]        cmd_num_tiles,
   output logic              cmd_ready,
   output logic              mem_rd_en,
   output logic [ADDR_W-1:0] mem_rd_addr,
   input  logic              mem_rd_gnt,
   input  logic              mem_rd_valid,
   input  logic [15:0]       mem_rd_data,
   input  logic              wt_fifo_full,
   output logic              wt_fifo_wr,
   output logic [15:0]       wt_fifo_data,
   output logic [1:0]        wt_col,
   output logic [1:0]        wt_row,
   output logic              wt_busy,
   output logic              wt_done,
   output logic              proto_err
);

   localparam int unsigned K_W    = 4;
   localparam int unsigned BEAT_W = 3;
   localparam int unsigned TILE_W = 8;
   localparam logic [K_W-1:0] K_LAST = K_W'(TILE_ELEMS - 1);

   typedef enum logic [2:0] {
      IDLE    = 3'd0,
      REQ     = 3'd1,
      WAIT    = 3'd2,
      PUSH_LO = 3'd3,
      PUSH_HI = 3'd4,
      FIN     = 3'd5
   } state_t;

   state_t              state, state_n;
   logic [ADDR_W-1:0]   base_addr, base_addr_n;
   logic [TILE_W-1:0]   num_tiles, num_tiles_n;
   logic [TILE_W-1:0]   tile_cnt, tile_cnt_n;
   logic [BEAT_W-1:0]   beat_cnt, beat_cnt_n;
   logic [K_W-1:0]      k_cnt, k_cnt_n;
   logic [1:0]          col_cnt, col_cnt_n;
   logic [1:0]          row_cnt, row_cnt_n;
   logic [15:0]         beat_data, beat_data_n;

   logic                cmd_ready_n, mem_rd_en_n, wt_fifo_wr_n;
   logic                wt_busy_n, wt_done_n, proto_err_n;
   logic [ADDR_W-1:0]   mem_rd_addr_n;
   logic [15:0]         wt_fifo_data_n;
   logic [1:0]          wt_col_n, wt_row_n;

   // Next-state, counter and registered-output logic
   always_comb begin
      state_n        = state;
      base_addr_n    = base_addr;
      num_tiles_n    = num_tiles;
      tile_cnt_n     = tile_cnt;
      beat_cnt_n     = beat_cnt;
      k_cnt_n        = k_cnt;
      col_cnt_n      = col_cnt;
      row_cnt_n      = row_cnt;
      beat_data_n    = beat_data;
      wt_fifo_wr_n   = 1'b0;
      wt_fifo_data_n = 16'h0000;
      wt_col_n       = 2'd0;
      wt_row_n       = 2'd0;
      // Stray read data is dropped but flagged until the next reset
      proto_err_n    = proto_err | (mem_rd_valid && (state != WAIT));

      case (state)
         IDLE: begin
            if (cmd_start) begin
               base_addr_n = cmd_addr;
               num_tiles_n = cmd_num_tiles;
               tile_cnt_n  = '0;
               beat_cnt_n  = '0;
               k_cnt_n     = '0;
               col_cnt_n   = '0;
               row_cnt_n   = '0;
               state_n     = (cmd_num_tiles == 8'd0) ? FIN : REQ;
            end
         end
         REQ: begin
            if (mem_rd_gnt) state_n = WAIT;
         end
         WAIT: begin
            if (mem_rd_valid) begin
               beat_data_n = mem_rd_data;
               state_n     = PUSH_LO;
            end
         end
         PUSH_LO: begin
            if (!wt_fifo_full) begin
               wt_fifo_wr_n   = 1'b1;
               wt_fifo_data_n = {8'h00, beat_data[7:0]};
               wt_col_n       = col_cnt;
               wt_row_n       = row_cnt;
               if (k_cnt == K_LAST) begin
                  // Last weight of the tile: the pad byte is skipped
                  tile_cnt_n = TILE_W'(tile_cnt + 1'b1);
                  beat_cnt_n = '0;
                  k_cnt_n    = '0;
                  col_cnt_n  = '0;
                  row_cnt_n  = '0;
                  state_n    = (TILE_W'(tile_cnt + 1'b1) == num_tiles) ? FIN : REQ;
               end else begin
                  k_cnt_n   = K_W'(k_cnt + 1'b1);
                  col_cnt_n = (col_cnt == 2'd2) ? 2'd0 : 2'(col_cnt + 1'b1);
                  row_cnt_n = (col_cnt == 2'd2) ? 2'(row_cnt + 1'b1) : row_cnt;
                  state_n   = PUSH_HI;
               end
            end
         end
         PUSH_HI: begin
            if (!wt_fifo_full) begin
               wt_fifo_wr_n   = 1'b1;
               wt_fifo_data_n = {8'h00, beat_data[15:8]};
               wt_col_n       = col_cnt;
               wt_row_n       = row_cnt;
               k_cnt_n        = K_W'(k_cnt + 1'b1);
               col_cnt_n      = (col_cnt == 2'd2) ? 2'd0 : 2'(col_cnt + 1'b1);
               row_cnt_n      = (col_cnt == 2'd2) ? 2'(row_cnt + 1'b1) : row_cnt;
               beat_cnt_n     = BEAT_W'(beat_cnt + 1'b1);
               state_n        = REQ;
            end
         end
         FIN: begin
            state_n = IDLE;
         end
         default: begin
            state_n = IDLE;
         end
      endcase

      // Status/request outputs track the state being entered
      cmd_ready_n   = (state_n == IDLE);
      wt_busy_n     = (state_n != IDLE);
      wt_done_n     = (state_n == FIN);
      mem_rd_en_n   = (state_n == REQ);
      mem_rd_addr_n = (state_n == REQ)
                    ? ADDR_W'(base_addr_n + ADDR_W'(32'(tile_cnt_n) * BEATS_TILE)
                              + ADDR_W'(beat_cnt_n))
                    : '0;
   end

   // State, counters and registered outputs with synchronous reset
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state        <= IDLE;
         base_addr    <= '0;
         num_tiles    <= '0;
         tile_cnt     <= '0;
         beat_cnt     <= '0;
         k_cnt        <= '0;
         col_cnt      <= '0;
         row_cnt      <= '0;
         beat_data    <= '0;
         cmd_ready    <= 1'b1;
         mem_rd_en    <= 1'b0;
         mem_rd_addr  <= '0;
         wt_fifo_wr   <= 1'b0;
         wt_fifo_data <= '0;
         wt_col       <= '0;
         wt_row       <= '0;
         wt_busy      <= 1'b0;
         wt_done      <= 1'b0;
         proto_err    <= 1'b0;
      end else begin
         state        <= state_n;
         base_addr    <= base_addr_n;
         num_tiles    <= num_tiles_n;
         tile_cnt     <= tile_cnt_n;
         beat_cnt     <= beat_cnt_n;
         k_cnt        <= k_cnt_n;
         col_cnt      <= col_cnt_n;
         row_cnt      <= row_cnt_n;
         beat_data    <= beat_data_n;
         cmd_ready    <= cmd_ready_n;
         mem_rd_en    <= mem_rd_en_n;
         mem_rd_addr  <= mem_rd_addr_n;
         wt_fifo_wr   <= wt_fifo_wr_n;
         wt_fifo_data <= wt_fifo_data_n;
         wt_col       <= wt_col_n;
         wt_row       <= wt_row_n;
         wt_busy      <= wt_busy_n;
         wt_done      <= wt_done_n;
         proto_err    <= proto_err_n;
      end
   end

endmodule

// File: tb/tb_weight_tile_loader.sv
// Directed self-checking bench for weight_tile_loader.
module tb_weight_tile_loader;

   localparam int unsigned ADDR_W = 24;

   logic              clk = 1'b0;
   logic              rst_n;
   logic              cmd_start;
   logic [ADDR_W-1:0] cmd_addr;
   logic [7:0]        cmd_num_tiles;
   logic              cmd_ready;
   logic              mem_rd_en;
   logic [ADDR_W-1:0] mem_rd_addr;
   logic              mem_rd_gnt;
   logic              mem_rd_valid;
   logic [15:0]       mem_rd_data;
   logic              wt_fifo_full;
   logic              wt_fifo_wr;
   logic [15:0]       wt_fifo_data;
   logic [1:0]        wt_col;
   logic [1:0]        wt_row;
   logic              wt_busy;
   logic              wt_done;
   logic              proto_err;

   weight_tile_loader dut (
      .clk           (clk),
      .rst_n         (rst_n),
      .cmd_start     (cmd_start),
      .cmd_addr      (cmd_addr),
      .cmd_num_tiles (cmd_num_tiles),
      .cmd_ready     (cmd_ready),
      .mem_rd_en     (mem_rd_en),
      .mem_rd_addr   (mem_rd_addr),
      .mem_rd_gnt    (mem_rd_gnt),
      .mem_rd_valid  (mem_rd_valid),
      .mem_rd_data   (mem_rd_data),
      .wt_fifo_full  (wt_fifo_full),
      .wt_fifo_wr    (wt_fifo_wr),
      .wt_fifo_data  (wt_fifo_data),
      .wt_col        (wt_col),
      .wt_row        (wt_row),
      .wt_busy       (wt_busy),
      .wt_done       (wt_done),
      .proto_err     (proto_err)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic [15:0] data;
      logic [1:0]  col;
      logic [1:0]  row;
   } push_t;

   int checks = 0;
   int errors = 0;

   push_t             push_q[$];
   logic [ADDR_W-1:0] rd_q[$];
   int done_cnt  = 0;
   int addr_viol = 0;
   int full_viol = 0;
   int gnt_delay = 0;
   logic inject_valid = 1'b0;

   // Memory model: grants after gnt_delay request cycles, returns data next cycle
   logic        pend = 1'b0;
   logic [15:0] pend_data = 16'h0;
   int          wait_cnt = 0;
   always @(negedge clk) begin
      if (rst_n !== 1'b1) begin
         pend = 1'b0; wait_cnt = 0;
         mem_rd_gnt = 1'b0; mem_rd_valid = 1'b0; mem_rd_data = 16'h0;
      end else begin
         mem_rd_valid = pend | inject_valid;
         mem_rd_data  = pend ? pend_data : 16'hBEEF;
         pend = 1'b0;
         mem_rd_gnt = 1'b0;
         if (mem_rd_en) begin
            if (wait_cnt < gnt_delay) wait_cnt++;
            else begin
               mem_rd_gnt = 1'b1;
               wait_cnt   = 0;
               rd_q.push_back(mem_rd_addr);
               pend       = 1'b1;
               pend_data  = {8'(mem_rd_addr * 2 + 1), 8'(mem_rd_addr * 2)};
            end
         end
      end
   end

   // Values the DUT saw at the last active edge
   logic              full_s = 1'b0, en_s = 1'b0, gnt_s = 1'b0;
   logic [ADDR_W-1:0] addr_s = '0;
   always @(posedge clk) begin
      full_s <= wt_fifo_full;
      en_s   <= mem_rd_en;
      gnt_s  <= mem_rd_gnt;
      addr_s <= mem_rd_addr;
   end

   // Push/done/request-stability monitor
   always @(negedge clk) begin
      if (wt_fifo_wr === 1'b1) begin
         push_q.push_back('{data: wt_fifo_data, col: wt_col, row: wt_row});
         if (full_s) full_viol++;
      end
      if (wt_done === 1'b1) done_cnt++;
      if (rst_n === 1'b1 && en_s && !gnt_s && (!mem_rd_en || mem_rd_addr !== addr_s))
         addr_viol++;
   end

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(negedge clk);
      #1;
   endtask

   task automatic start_cmd(input logic [ADDR_W-1:0] a, input logic [7:0] n);
      cmd_addr = a; cmd_num_tiles = n; cmd_start = 1'b1;
      tick();
      cmd_start = 1'b0;
   endtask

   task automatic wait_done(input int d0, input string tag);
      int n = 0;
      while (done_cnt == d0 && n < 3000) begin tick(); n++; end
      chk({tag, "_timeout"}, 32'(n < 3000), 32'd1);
      repeat (4) tick();
   endtask

   // Compare reads and pushes of a completed command against the packed layout
   task automatic check_load(input string tag, input int r0, input int p0,
                             input logic [ADDR_W-1:0] base, input int ntiles);
      logic [ADDR_W-1:0] a;
      logic [7:0]        b;
      chk({tag, "_reads"}, 32'(rd_q.size() - r0), 32'(ntiles * 5));
      chk({tag, "_pushes"}, 32'(push_q.size() - p0), 32'(ntiles * 9));
      for (int i = 0; i < ntiles * 5 && r0 + i < rd_q.size(); i++)
         chk($sformatf("%s_addr%0d", tag, i), 32'(rd_q[r0 + i]), 32'(ADDR_W'(base + ADDR_W'(i))));
      for (int t = 0; t < ntiles; t++)
         for (int k = 0; k < 9; k++) begin
            int idx = p0 + t * 9 + k;
            if (idx < push_q.size()) begin
               a = ADDR_W'(base + ADDR_W'(t * 5 + k / 2));
               b = 8'(a * 2 + ADDR_W'(k % 2));
               chk($sformatf("%s_data%0d_%0d", tag, t, k), 32'(push_q[idx].data), 32'({8'h00, b}));
               chk($sformatf("%s_col%0d_%0d", tag, t, k), 32'(push_q[idx].col), 32'(k % 3));
               chk($sformatf("%s_row%0d_%0d", tag, t, k), 32'(push_q[idx].row), 32'(k / 3));
            end
         end
   endtask

   initial begin
      int r0, p0, d0, n;
      rst_n = 1'b0; cmd_start = 1'b0; cmd_addr = '0; cmd_num_tiles = '0;
      wt_fifo_full = 1'b0;
      repeat (3) tick();

      // Reset state
      chk("rst_cmd_ready", 32'(cmd_ready), 32'd1);
      chk("rst_busy", 32'(wt_busy), 32'd0);
      chk("rst_done", 32'(wt_done), 32'd0);
      chk("rst_rd_en", 32'(mem_rd_en), 32'd0);
      chk("rst_rd_addr", 32'(mem_rd_addr), 32'd0);
      chk("rst_fifo_wr", 32'(wt_fifo_wr), 32'd0);
      chk("rst_proto_err", 32'(proto_err), 32'd0);
      rst_n = 1'b1;
      repeat (2) tick();

      // One tile at 0x000100, immediate memory
      r0 = rd_q.size(); p0 = push_q.size(); d0 = done_cnt;
      start_cmd(24'h000100, 8'd1);
      chk("t1_busy", 32'(wt_busy), 32'd1);
      chk("t1_ready", 32'(cmd_ready), 32'd0);
      wait_done(d0, "t1");
      check_load("t1", r0, p0, 24'h000100, 1);
      chk("t1_done_cnt", 32'(done_cnt - d0), 32'd1);
      chk("t1_idle", 32'(cmd_ready), 32'd1);

      // Three tiles wrapping the address space
      r0 = rd_q.size(); p0 = push_q.size(); d0 = done_cnt;
      start_cmd(24'hFFFFFE, 8'd3);
      wait_done(d0, "t2");
      check_load("t2", r0, p0, 24'hFFFFFE, 3);
      chk("t2_done_cnt", 32'(done_cnt - d0), 32'd1);

      // Zero tiles: done/busy for exactly one cycle, no reads
      r0 = rd_q.size(); p0 = push_q.size(); d0 = done_cnt;
      start_cmd(24'h000500, 8'd0);
      chk("t3_done_hi", 32'(wt_done), 32'd1);
      chk("t3_busy_hi", 32'(wt_busy), 32'd1);
      chk("t3_ready_lo", 32'(cmd_ready), 32'd0);
      tick();
      chk("t3_done_lo", 32'(wt_done), 32'd0);
      chk("t3_busy_lo", 32'(wt_busy), 32'd0);
      chk("t3_ready_hi", 32'(cmd_ready), 32'd1);
      repeat (3) tick();
      chk("t3_reads", 32'(rd_q.size() - r0), 32'd0);
      chk("t3_pushes", 32'(push_q.size() - p0), 32'd0);
      chk("t3_done_cnt", 32'(done_cnt - d0), 32'd1);

      // Slow grants plus a FIFO-full stall mid-tile
      gnt_delay = 4;
      r0 = rd_q.size(); p0 = push_q.size(); d0 = done_cnt;
      start_cmd(24'h000200, 8'd1);
      n = 0;
      while (push_q.size() - p0 < 5 && n < 3000) begin tick(); n++; end
      chk("t4_reach5", 32'(push_q.size() - p0), 32'd5);
      wt_fifo_full = 1'b1;
      repeat (3) tick();
      chk("t4_stalled", 32'(push_q.size() - p0), 32'd5);
      wt_fifo_full = 1'b0;
      wait_done(d0, "t4");
      check_load("t4", r0, p0, 24'h000200, 1);
      chk("t4_full_viol", 32'(full_viol), 32'd0);
      chk("t4_addr_viol", 32'(addr_viol), 32'd0);
      gnt_delay = 0;

      // Reset during PUSH_HI of tile 1 abandons the load
      p0 = push_q.size(); d0 = done_cnt;
      start_cmd(24'h000100, 8'd2);
      n = 0;
      while (push_q.size() - p0 < 10 && n < 3000) begin tick(); n++; end
      chk("t5_reach10", 32'(push_q.size() - p0), 32'd10);
      rst_n = 1'b0;
      tick();
      rst_n = 1'b1;
      chk("t5_rst_ready", 32'(cmd_ready), 32'd1);
      chk("t5_rst_busy", 32'(wt_busy), 32'd0);
      repeat (6) tick();
      chk("t5_no_more_push", 32'(push_q.size() - p0), 32'd10);
      chk("t5_no_done", 32'(done_cnt - d0), 32'd0);
      r0 = rd_q.size(); p0 = push_q.size(); d0 = done_cnt;
      start_cmd(24'h000100, 8'd1);
      wait_done(d0, "t5b");
      check_load("t5b", r0, p0, 24'h000100, 1);
      chk("t5b_done_cnt", 32'(done_cnt - d0), 32'd1);

      // Stray read data in IDLE sets the sticky error and pushes nothing
      chk("t6_err_before", 32'(proto_err), 32'd0);
      p0 = push_q.size();
      inject_valid = 1'b1;
      tick();
      inject_valid = 1'b0;
      repeat (2) tick();
      chk("t6_err_set", 32'(proto_err), 32'd1);
      repeat (5) tick();
      chk("t6_err_sticky", 32'(proto_err), 32'd1);
      chk("t6_no_push", 32'(push_q.size() - p0), 32'd0);
      chk("t6_idle", 32'(cmd_ready), 32'd1);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
